fetch_queue_ctrl: RTL and testbench

Instruction fetch controller for the 16×16 instruction memory. It owns the memory's Address/Wren/Din port and sequences a 4-bit program counter through synchronous one-cycle-latency reads, buffering fetched words in a small FIFO with a valid/ready handshake toward the issue stage. It also arbitrates a loader write port onto the same memory port, and halts on a NOP word (16'h0000).

---
 rtl/fetch_queue_ctrl.sv | 158 +++++++++++++++
 tb/tb_fetch_queue_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_ctrl.sv
// Instruction fetch controller: sequences the PC through a 1-cycle sync memory and queues fetched words.
// Latency: Start at edge N -> read issued edge N+1 -> Instr_valid after edge N+2; one word/cycle sustained.
// Backpressure: Instr_valid/Instr_ready on the queue head; reads stop once queued + in-flight words reach DEPTH.
//
// Ports:
//   Clock, Reset                 rising-edge clock, synchronous active-high reset
//   Start                        begin/resume fetching from IDLE or HALT
//   Flush, Flush_pc              drop queue and in-flight read, redirect PC
//   Ld_req/Ld_addr/Ld_data       loader write request (priority over fetch), Ld_ack = accepted
//   Mem_addr/Mem_wren/Mem_din    drive the instruction memory port, Mem_q = its read data
//   Instr/Instr_pc/Instr_valid   queue head word, its address, queue non-empty
//   Instr_ready                  issue stage consumes the head
//   Busy / Halted                fetching / stopped on a NOP word
module fetch_queue_ctrl #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Flush,
    input  logic [ADDR_W-1:0] Flush_pc,
    input  logic              Ld_req,
    input  logic [ADDR_W-1:0] Ld_addr,
    input  logic [DATA_W-1:0] Ld_data,
    output logic              Ld_ack,
    output logic [ADDR_W-1:0] Mem_addr,
    output logic              Mem_wren,
    output logic [DATA_W-1:0] Mem_din,
    input  logic [DATA_W-1:0] Mem_q,
    output logic [DATA_W-1:0] Instr,
    output logic [ADDR_W-1:0] Instr_pc,
    output logic              Instr_valid,
    input  logic              Instr_ready,
    output logic              Busy,
    output logic              Halted
);

    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;

    // One spare bit so count + in-flight can never wrap before the compare.
    localparam logic [PTR_W+1:0] DEPTH_L = (PTR_W+2)'(DEPTH);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [PTR_W:0]    cnt_q, cnt_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic              infl_q, infl_d;
    logic [ADDR_W-1:0] infl_pc_q, infl_pc_d;

    logic [DATA_W-1:0] data_q [DEPTH];
    logic [ADDR_W-1:0] pcbuf_q [DEPTH];

    logic              ld_go;
    logic              fetching;
    logic [PTR_W+1:0]  occupancy;
    logic              issue;
    logic              ret_ok;
    logic              ret_nop;
    logic              push;
    logic              pop;

    // Loader owns the memory port whenever it asks; fetch simply yields that cycle.
    assign ld_go    = Ld_req && !Reset;
    assign Ld_ack   = ld_go;
    assign Mem_wren = ld_go;
    assign Mem_addr = ld_go ? Ld_addr : pc_q;
    assign Mem_din  = ld_go ? Ld_data : '0;

    assign fetching  = (state_q == S_FETCH);
    // Registered count plus the outstanding read reserves a slot for every read issued.
    assign occupancy = {1'b0, cnt_q} + (PTR_W+2)'(infl_q);
    assign issue     = fetching && !Ld_req && !Flush && (occupancy < DEPTH_L);

    // A read returning after the NOP-driven halt belongs to a stale address and is dropped.
    assign ret_ok  = infl_q && fetching;
    assign ret_nop = ret_ok && (Mem_q == '0);
    assign push    = ret_ok && !ret_nop;
    assign pop     = (cnt_q != '0) && Instr_ready;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cnt_d     = cnt_q;
        head_d    = head_q;
        tail_d    = tail_q;
        infl_d    = 1'b0;
        infl_pc_d = infl_pc_q;
        if (Flush) begin
            state_d = S_FETCH;
            pc_d    = Flush_pc;
            cnt_d   = '0;
            head_d  = '0;
            tail_d  = '0;
        end else begin
            if (issue) begin
                infl_d    = 1'b1;
                infl_pc_d = pc_q;
                pc_d      = pc_q + ADDR_W'(1);
            end
            if (push) begin
                tail_d = tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            cnt_d = cnt_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
            // Rewind to the NOP address so a later Start re-reads it (it may be reloaded).
            if (ret_nop) begin
                state_d = S_HALT;
                pc_d    = infl_pc_q;
            end else if ((state_q != S_FETCH) && Start) begin
                state_d = S_FETCH;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            cnt_q     <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            infl_q    <= 1'b0;
            infl_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            infl_q    <= infl_d;
            infl_pc_q <= infl_pc_d;
        end
    end

    // Queue storage needs no reset: entries are only visible while count covers them.
    always_ff @(posedge Clock) begin
        if (push && !Flush && !Reset) begin
            data_q[tail_q]  <= Mem_q;
            pcbuf_q[tail_q] <= infl_pc_q;
        end
    end

    assign Instr_valid = (cnt_q != '0);
    assign Instr       = Instr_valid ? data_q[head_q]  : '0;
    assign Instr_pc    = Instr_valid ? pcbuf_q[head_q] : '0;
    assign Busy        = (state_q == S_FETCH);
    assign Halted      = (state_q == S_HALT);

endmodule

// File: tb/tb_fetch_queue_ctrl.sv
// Bench for fetch_queue_ctrl: 16x16 sync memory model, cycle reference model built on a queue,
// table-driven loader vectors, directed corner sequences, then randomized traffic.
// Stimulus driven at posedge+1, outputs checked at posedge+3 (combinational) and posedge+1 (registered).
module tb_fetch_queue_ctrl;

    localparam int DEPTH = 4;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic        Flush = 1'b0;
    logic [3:0]  Flush_pc = 4'h0;
    logic        Ld_req = 1'b0;
    logic [3:0]  Ld_addr = 4'h0;
    logic [15:0] Ld_data = 16'h0;
    logic        Ld_ack;
    logic [3:0]  Mem_addr;
    logic        Mem_wren;
    logic [15:0] Mem_din;
    logic [15:0] Mem_q = 16'h0;
    logic [15:0] Instr;
    logic [3:0]  Instr_pc;
    logic        Instr_valid;
    logic        Instr_ready = 1'b0;
    logic        Busy;
    logic        Halted;

    fetch_queue_ctrl #(.DEPTH(4), .ADDR_W(4), .DATA_W(16)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Flush(Flush), .Flush_pc(Flush_pc),
        .Ld_req(Ld_req), .Ld_addr(Ld_addr), .Ld_data(Ld_data), .Ld_ack(Ld_ack),
        .Mem_addr(Mem_addr), .Mem_wren(Mem_wren), .Mem_din(Mem_din), .Mem_q(Mem_q),
        .Instr(Instr), .Instr_pc(Instr_pc), .Instr_valid(Instr_valid), .Instr_ready(Instr_ready),
        .Busy(Busy), .Halted(Halted)
    );

    always #5 Clock = ~Clock;

    // Instruction memory: one-cycle read latency, Q echoes Din on a write cycle.
    logic [15:0] mem [16] = '{default: 16'h0};
    always @(posedge Clock) begin
        if (Mem_wren) mem[Mem_addr] <= Mem_din;
        Mem_q <= Mem_wren ? Mem_din : mem[Mem_addr];
    end

    // ---------------- reference model ----------------
    typedef struct { logic [15:0] w; logic [3:0] pc; } ent_t;
    typedef enum { M_IDLE, M_FETCH, M_HALT } mstate_t;

    ent_t        mq[$];
    mstate_t     m_state = M_IDLE;
    logic [3:0]  m_pc = 4'h0;
    bit          m_inf = 1'b0;
    logic [3:0]  m_ipc = 4'h0;
    logic [15:0] m_iw = 16'h0;
    logic [15:0] mmem [16] = '{default: 16'h0};

    ent_t got[$];
    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        ent_t e;
        bit issue, pop, ret_push, ret_nop;
        logic [3:0] ipc_old;
        if (Reset) begin
            mq.delete();
            m_state = M_IDLE; m_pc = 4'h0; m_inf = 1'b0; m_ipc = 4'h0;
            return;
        end
        issue = (m_state == M_FETCH) && !Ld_req && !Flush && ((mq.size() + int'(m_inf)) < DEPTH);
        pop   = (mq.size() > 0) && Instr_ready;
        if (Ld_req) mmem[Ld_addr] = Ld_data;
        if (Flush) begin
            mq.delete();
            m_inf = 1'b0; m_pc = Flush_pc; m_state = M_FETCH;
            return;
        end
        ret_push = m_inf && (m_state == M_FETCH) && (m_iw != 16'h0);
        ret_nop  = m_inf && (m_state == M_FETCH) && (m_iw == 16'h0);
        if (pop) void'(mq.pop_front());
        if (ret_push) begin e.w = m_iw; e.pc = m_ipc; mq.push_back(e); end
        ipc_old = m_ipc;
        if (issue) begin
            m_iw = mmem[m_pc]; m_ipc = m_pc; m_pc = m_pc + 4'h1;
        end
        m_inf = issue;
        if (ret_nop) begin
            m_state = M_HALT; m_pc = ipc_old;
        end else if (m_state != M_FETCH && Start) begin
            m_state = M_FETCH;
        end
    endtask

    // One clock: check memory-port outputs, record handshakes, step model, check registered outputs.
    task automatic tick();
        ent_t e;
        #2;
        if (!Reset && Ld_req) begin
            chk("mem_wren", Mem_wren, 1); chk("mem_addr", Mem_addr, Ld_addr);
            chk("mem_din", Mem_din, Ld_data); chk("ld_ack", Ld_ack, 1);
        end else begin
            chk("mem_wren", Mem_wren, 0); chk("mem_addr", Mem_addr, m_pc);
            chk("mem_din", Mem_din, 0); chk("ld_ack", Ld_ack, 0);
        end
        if (Instr_valid && Instr_ready) begin e.w = Instr; e.pc = Instr_pc; got.push_back(e); end
        model_step();
        @(posedge Clock); #1;
        chk("instr_valid", Instr_valid, mq.size() > 0);
        chk("busy", Busy, m_state == M_FETCH);
        chk("halted", Halted, m_state == M_HALT);
        if (mq.size() > 0) begin
            chk("instr", Instr, mq[0].w);
            chk("instr_pc", Instr_pc, mq[0].pc);
        end
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        Reset = 1'b1; tick(); Reset = 1'b0;
    endtask

    task automatic load(input logic [3:0] a, input logic [15:0] d);
        Ld_req = 1'b1; Ld_addr = a; Ld_data = d; tick(); Ld_req = 1'b0;
    endtask

    task automatic run_until_halt(input int bound);
        int n = 0;
        while (!Halted && n < bound) begin tick(); n++; end
        chk("halt_reached", Halted, 1);
    endtask

    task automatic chk_got(input string nm, input int idx, input logic [15:0] w, input logic [3:0] pc);
        if (got.size() > idx) begin
            chk({nm, "_word"}, got[idx].w, w);
            chk({nm, "_pc"}, got[idx].pc, pc);
        end else begin
            chk({nm, "_missing"}, got.size(), idx + 1);
        end
    endtask

    typedef struct {
        bit rst; bit ld; logic [3:0] a; logic [15:0] d;
        bit ew; logic [3:0] ea; logic [15:0] ed; bit ek;
    } vec_t;

    initial begin
        vec_t vt[12];
        logic [15:0] prog [8];
        prog = '{16'h20A0, 16'h40A0, 16'h20A0, 16'h20A0, 16'h20A0, 16'h20A0, 16'h40A0, 16'h0000};
        vt[0]  = '{1, 0, 4'h3, 16'h1234, 0, 4'h0, 16'h0, 0};
        vt[1]  = '{1, 1, 4'h9, 16'hFFFF, 0, 4'h0, 16'h0, 0};
        for (int i = 0; i < 8; i++)
            vt[2+i] = '{0, 1, 4'(i), prog[i], 1, 4'(i), prog[i], 1};
        vt[10] = '{0, 0, 4'h5, 16'hBEEF, 0, 4'h0, 16'h0, 0};
        vt[11] = '{0, 1, 4'h9, 16'h0000, 1, 4'h9, 16'h0, 1};

        // Initial reset and reset-state outputs.
        Reset = 1'b1;
        @(posedge Clock); #1;
        chk("rst_valid", Instr_valid, 0); chk("rst_busy", Busy, 0); chk("rst_halted", Halted, 0);
        chk("rst_instr", Instr, 0); chk("rst_instr_pc", Instr_pc, 0);

        // Table: memory-port arbitration from IDLE, also loads the program.
        for (int i = 0; i < 12; i++) begin
            Reset = vt[i].rst; Ld_req = vt[i].ld; Ld_addr = vt[i].a; Ld_data = vt[i].d;
            #1;
            chk("vec_wren", Mem_wren, vt[i].ew); chk("vec_addr", Mem_addr, vt[i].ea);
            chk("vec_din", Mem_din, vt[i].ed);   chk("vec_ack", Ld_ack, vt[i].ek);
            tick();
        end
        Reset = 1'b0; Ld_req = 1'b0;

        // Straight-line program, issue stage always ready.
        got.delete(); Instr_ready = 1'b1; Start = 1'b1;
        tick(); Start = 1'b0;
        chk("lat_busy", Busy, 1);
        tick(); chk("lat_n1_valid", Instr_valid, 0);
        tick(); chk("lat_n2_valid", Instr_valid, 1); chk("lat_n2_pc", Instr_pc, 0);
        run_until_halt(40); run(3);
        chk("prog_count", got.size(), 7);
        for (int i = 0; i < 7; i++) chk_got("prog", i, prog[i], 4'(i));
        chk("prog_busy", Busy, 0);

        // Backpressure: queue fills, reads stop, then drains in order.
        do_reset(); got.delete(); Instr_ready = 1'b0; Start = 1'b1;
        tick(); Start = 1'b0; run(10);
        chk("bp_valid", Instr_valid, 1); chk("bp_head", Instr, 16'h20A0);
        chk("bp_head_pc", Instr_pc, 0); chk("bp_pc_stalled", Mem_addr, 4);
        Instr_ready = 1'b1;
        run_until_halt(40); run(3);
        chk("bp_count", got.size(), 7);
        for (int i = 0; i < 7; i++) chk_got("bp", i, prog[i], 4'(i));

        // Loader write during FETCH.
        do_reset(); got.delete(); Instr_ready = 1'b1; Start = 1'b1;
        tick(); Start = 1'b0; tick();
        Ld_req = 1'b1; Ld_addr = 4'h7; Ld_data = 16'h6000;
        #1; chk("ldf_ack", Ld_ack, 1); chk("ldf_wren", Mem_wren, 1);
        tick(); Ld_req = 1'b0;
        run_until_halt(40); run(3);
        chk("ldf_count", got.size(), 8);
        chk_got("ldf7", 7, 16'h6000, 4'h7);
        chk("ldf_halt_pc", Mem_addr, 8);
        load(4'h7, 16'h0000);

        // Flush with three queued entries and a read in flight.
        do_reset(); got.delete(); Instr_ready = 1'b0; Start = 1'b1;
        tick(); Start = 1'b0;
        for (int n = 0; n < 12 && !(mq.size() == 3 && m_inf); n++) tick();
        chk("fl_prefill", Instr_valid, 1);
        Flush = 1'b1; Flush_pc = 4'h3; tick(); Flush = 1'b0;
        chk("fl_valid", Instr_valid, 0);
        Instr_ready = 1'b1;
        run_until_halt(40); run(3);
        chk("fl_count", got.size(), 4);
        chk_got("fl_first", 0, 16'h20A0, 4'h3);

        // Flush to 14 wraps through 15 -> 0.
        load(4'hE, 16'h1111); load(4'hF, 16'h2222);
        got.delete(); Flush = 1'b1; Flush_pc = 4'hE; tick(); Flush = 1'b0;
        run_until_halt(40); run(3);
        chk_got("wrap0", 0, 16'h1111, 4'hE);
        chk_got("wrap1", 1, 16'h2222, 4'hF);
        chk_got("wrap2", 2, 16'h20A0, 4'h0);
        chk("halt_at7", Mem_addr, 7);

        // Resume from HALT after patching the NOP.
        load(4'h7, 16'h20A0);
        got.delete(); Start = 1'b1; tick(); Start = 1'b0; run(5);
        chk_got("resume", 0, 16'h20A0, 4'h7);

        // Reset mid-stream.
        do_reset(); Instr_ready = 1'b0; Start = 1'b1; tick(); Start = 1'b0; run(4);
        chk("mid_pre_valid", Instr_valid, 1);
        Reset = 1'b1; tick();
        chk("mid_valid", Instr_valid, 0); chk("mid_busy", Busy, 0); chk("mid_halted", Halted, 0);
        chk("mid_instr", Instr, 0); chk("mid_instr_pc", Instr_pc, 0);
        chk("mid_addr", Mem_addr, 0); chk("mid_wren", Mem_wren, 0);
        chk("mid_din", Mem_din, 0); chk("mid_ack", Ld_ack, 0);
        Reset = 1'b0;

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            Reset       = ($urandom_range(0, 99) == 0);
            Start       = ($urandom_range(0, 7) == 0);
            Flush       = ($urandom_range(0, 24) == 0);
            Flush_pc    = 4'($urandom_range(0, 15));
            Ld_req      = ($urandom_range(0, 5) == 0);
            Ld_addr     = 4'($urandom_range(0, 15));
            Ld_data     = ($urandom_range(0, 2) == 0) ? 16'h0 : 16'($urandom_range(1, 65535));
            Instr_ready = ($urandom_range(0, 1) == 1);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
